mips32_hazard_ctrl: RTL and testbench

//  Issue-interlock controller for the MIPS32 5-stage pipeline. Removes hand-inserted OR R20,R20,R20 NOPs.

---
 rtl/mips32_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_mips32_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mips32_hazard_ctrl.sv
// Issue interlock for the MIPS32 5-stage pipeline.
// Holds ID on scoreboard hazards, waits out branches, squashes wrong-path fetches, freezes on HLT.
module mips32_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk_1,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_wr_en,
  input  logic [4:0]             id_wr_reg,
  input  logic                   id_is_branch,
  input  logic                   id_is_halt,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_reg,
  input  logic                   br_resolve,
  input  logic                   br_taken,
  output logic                   issue,
  output logic                   stall,
  output logic                   flush,
  output logic                   halted,
  output logic [31:0]            pending,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_BR_WAIT,
    ST_FLUSH,
    ST_HALTED
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  state_t                 state;
  state_t                 state_nx;
  logic [2:0]             flush_cnt;
  logic [2:0]             flush_cnt_nx;
  logic [31:0]            pending_q;
  logic [31:0]            pending_nx;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   hazard;

  assign pending   = pending_q;
  assign stall_cnt = stall_cnt_q;

  // Registered scoreboard only: a write-back landing this cycle still costs one bubble.
  always_comb begin
    hazard = (id_use_rs & pending_q[id_rs])
           | (id_use_rt & pending_q[id_rt])
           | (id_wr_en  & pending_q[id_wr_reg]);
  end

  // Next state and pipeline controls.
  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    issue        = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_RUN: begin
        issue = id_valid & ~hazard;
        stall = id_valid & ~issue;
        if (issue && id_is_branch) begin
          state_nx = ST_BR_WAIT;
        end else if (issue && id_is_halt) begin
          state_nx = ST_HALTED;
        end
      end
      ST_BR_WAIT: begin
        stall = id_valid;
        if (br_resolve) begin
          if (br_taken) begin
            state_nx     = ST_FLUSH;
            flush_cnt_nx = 3'(FLUSH_CYCLES);
          end else begin
            state_nx = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        flush        = 1'b1;
        flush_cnt_nx = flush_cnt - 3'd1;
        if (flush_cnt <= 3'd1) begin
          state_nx     = ST_RUN;
          flush_cnt_nx = '0;
        end
      end
      ST_HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: begin
        state_nx = ST_RUN;
      end
    endcase
  end

  // Clear-then-set ordering makes a same-register retire/issue collision end up pending.
  always_comb begin
    pending_nx = pending_q;
    if (wb_valid) begin
      pending_nx[wb_reg] = 1'b0;
    end
    if (issue && id_wr_en) begin
      pending_nx[id_wr_reg] = 1'b1;
    end
    pending_nx[0] = 1'b0;
  end

  // State, scoreboard and saturating stall counter.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state       <= ST_RUN;
      flush_cnt   <= '0;
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      pending_q <= pending_nx;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Directed bench for mips32_hazard_ctrl; expectations queued per cycle, checked by a separate monitor.
module tb_mips32_hazard_ctrl;

  localparam int unsigned SCW = 4;

  logic           clk_1 = 1'b0;
  logic           rst;
  logic           id_valid;
  logic [4:0]     id_rs;
  logic [4:0]     id_rt;
  logic           id_use_rs;
  logic           id_use_rt;
  logic           id_wr_en;
  logic [4:0]     id_wr_reg;
  logic           id_is_branch;
  logic           id_is_halt;
  logic           wb_valid;
  logic [4:0]     wb_reg;
  logic           br_resolve;
  logic           br_taken;
  logic           issue;
  logic           stall;
  logic           flush;
  logic           halted;
  logic [31:0]    pending;
  logic [SCW-1:0] stall_cnt;

  typedef struct {
    string          name;
    logic           issue;
    logic           stall;
    logic           flush;
    logic           halted;
    logic [31:0]    pending;
    logic [SCW-1:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk_1 = ~clk_1;

  mips32_hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .STALL_CNT_W (SCW)
  ) dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wr_en    (id_wr_en),
    .id_wr_reg   (id_wr_reg),
    .id_is_branch(id_is_branch),
    .id_is_halt  (id_is_halt),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .issue       (issue),
    .stall       (stall),
    .flush       (flush),
    .halted      (halted),
    .pending     (pending),
    .stall_cnt   (stall_cnt)
  );

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (issue !== e.issue || stall !== e.stall || flush !== e.flush ||
            halted !== e.halted || pending !== e.pending || stall_cnt !== e.scnt) begin
          n_bad++;
          $display("FAIL %s: got issue=%b stall=%b flush=%b halted=%b pending=%h scnt=%0d, want issue=%b stall=%b flush=%b halted=%b pending=%h scnt=%0d",
                   e.name, issue, stall, flush, halted, pending, stall_cnt,
                   e.issue, e.stall, e.flush, e.halted, e.pending, e.scnt);
        end
      end
    end
  end

  task automatic instr(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic wen,
                       input logic [4:0] wreg, input logic br, input logic hlt);
    id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
    id_wr_en = wen;  id_wr_reg = wreg;  id_is_branch = br;  id_is_halt = hlt;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    wb_valid = v;  wb_reg = r;
  endtask

  task automatic brr(input logic res, input logic tk);
    br_resolve = res;  br_taken = tk;
  endtask

  // Push the expected outputs for the cycle just driven, then advance one clock.
  task automatic cyc(input string nm, input logic e_is, input logic e_st, input logic e_fl,
                     input logic e_ha, input logic [31:0] e_pd, input logic [SCW-1:0] e_sc);
    exp_t e;
    e.name = nm;  e.issue = e_is;  e.stall = e_st;  e.flush = e_fl;
    e.halted = e_ha;  e.pending = e_pd;  e.scnt = e_sc;
    exp_q.push_back(e);
    @(posedge clk_1);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);
    brr(0, 0);
    @(posedge clk_1);
    #1;
    cyc("reset", 0, 0, 0, 0, 32'h0, 0);

    rst = 1'b0;
    // RAW: LW R3,0(R1) then MUL R2,R2,R3
    instr(1, 1, 1, 0, 0, 1, 3, 0, 0);  cyc("lw_issue", 1, 0, 0, 0, 32'h0, 0);
    instr(1, 2, 1, 3, 1, 1, 2, 0, 0);  cyc("raw_stall1", 0, 1, 0, 0, 32'h8, 0);
    cyc("raw_stall2", 0, 1, 0, 0, 32'h8, 1);
    wb(1, 3);                           cyc("raw_wb_same_cycle", 0, 1, 0, 0, 32'h8, 2);
    wb(0, 0);                           cyc("raw_release", 1, 0, 0, 0, 32'h0, 3);

    // Collision: retire R2 while issuing a new write of R2
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 2);                           cyc("clear_r2", 0, 0, 0, 0, 32'h4, 3);
    instr(1, 4, 1, 5, 1, 1, 2, 0, 0);  cyc("collide_issue", 1, 0, 0, 0, 32'h0, 3);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);                           cyc("collide_set", 0, 0, 0, 0, 32'h4, 3);
    instr(1, 4, 1, 0, 0, 1, 0, 0, 0);  cyc("r0_write", 1, 0, 0, 0, 32'h4, 3);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 2);                           cyc("r0_never_pending", 0, 0, 0, 0, 32'h4, 3);
    wb(0, 0);

    // Taken branch: BNEQZ R3, resolve after three waiting cycles
    instr(1, 3, 1, 0, 0, 0, 0, 1, 0);  cyc("br_t_issue", 1, 0, 0, 0, 32'h0, 3);
    instr(1, 1, 1, 0, 0, 1, 6, 0, 0);  cyc("br_t_wait1", 0, 1, 0, 0, 32'h0, 3);
    cyc("br_t_wait2", 0, 1, 0, 0, 32'h0, 4);
    cyc("br_t_wait3", 0, 1, 0, 0, 32'h0, 5);
    brr(1, 1);                          cyc("br_t_resolve", 0, 1, 0, 0, 32'h0, 6);
    brr(0, 0);                          cyc("flush1", 0, 0, 1, 0, 32'h0, 7);
    cyc("flush2", 0, 0, 1, 0, 32'h0, 7);
    cyc("after_flush_issue", 1, 0, 0, 0, 32'h0, 7);

    // Not-taken branch: BEQZ R6 first waits on R6, then resolves not taken
    instr(1, 6, 1, 0, 0, 0, 0, 1, 0);
    wb(1, 6);                           cyc("br_n_hazard", 0, 1, 0, 0, 32'h40, 7);
    wb(0, 0);                           cyc("br_n_issue", 1, 0, 0, 0, 32'h0, 8);
    instr(1, 1, 1, 0, 0, 1, 7, 0, 0);  cyc("br_n_wait", 0, 1, 0, 0, 32'h0, 8);
    brr(1, 0);                          cyc("br_n_resolve", 0, 1, 0, 0, 32'h0, 9);
    brr(0, 0);                          cyc("br_n_resume", 1, 0, 0, 0, 32'h0, 10);

    // Stray resolve in RUN must be ignored
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    brr(1, 1);                          cyc("stray_resolve", 0, 0, 0, 0, 32'h80, 10);
    brr(0, 0);                          cyc("stray_no_flush", 0, 0, 0, 0, 32'h80, 10);

    // HLT: freeze, write-back still retires, counter saturates
    instr(1, 0, 0, 0, 0, 0, 0, 0, 1);  cyc("hlt_issue", 1, 0, 0, 0, 32'h80, 10);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 7);                           cyc("halted_wb", 0, 1, 0, 1, 32'h80, 10);
    wb(0, 0);
    instr(1, 1, 1, 0, 0, 1, 8, 0, 0);  cyc("halted_hold", 0, 1, 0, 1, 32'h0, 11);
    brr(1, 1);                          cyc("halted_br_ignored", 0, 1, 0, 1, 32'h0, 12);
    brr(0, 0);                          cyc("halted_cnt13", 0, 1, 0, 1, 32'h0, 13);
    cyc("halted_cnt14", 0, 1, 0, 1, 32'h0, 14);
    cyc("halted_sat", 0, 1, 0, 1, 32'h0, 15);
    cyc("halted_sat_hold", 0, 1, 0, 1, 32'h0, 15);

    // Reset from HALTED with a write-back in flight
    rst = 1'b1;
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 5);                           cyc("rst_from_halt", 0, 1, 0, 1, 32'h0, 15);
    rst = 1'b0;
    wb(0, 0);                           cyc("post_reset", 0, 0, 0, 0, 32'h0, 0);
    instr(1, 1, 1, 0, 0, 1, 9, 0, 0);  cyc("post_reset_issue", 1, 0, 0, 0, 32'h0, 0);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("post_reset_pending", 0, 0, 0, 0, 32'h200, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk_1);
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
